mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine between the EX/MEM register and the MEM/WB register.
//  Builds the byte-enables and lane-replicated write data, and runs a req/ack handshake
//  with the data memory. Stalls the pipeline for the duration of each access.
//  Delivers load data right-justified, so downstream sign/zero extension uses bits [7:0]/[15:0].
// PARAMETERS
//  MAX_WAIT  255  cycles in BUSY without dmem_ack before the access is aborted with bus_err
//  CNT_W     8    width of the wait counter; must satisfy 2**CNT_W > MAX_WAIT
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, asynchronous, active-high
//  mem_read      in   1   load in MEM stage
//  mem_write     in   1   store in MEM stage (mem_read and mem_write never both 1)
//  funct3        in   3   0=B 1=H 2=W 4=BU 5=HU (stores use 0..2)
//  addr          in   32  byte address (ALU result)
//  store_data    in   32  rs2 value
//  dmem_req      out  1   memory request, held until dmem_ack
//  dmem_we       out  1   1=write, 0=read
//  dmem_addr     out  32  word address {addr[31:2],2'b00}
//  dmem_be       out  4   byte enables, active-high
//  dmem_wdata    out  32  lane-replicated write data
//  dmem_rdata    in   32  read data, valid with dmem_ack
//  dmem_ack      in   1   access complete
//  load_data     out  32  rdata >> (8*addr[1:0]), registered; feeds MEM/WB load input
//  stall         out  1   1 = freeze IF..EX/MEM
//  bus_err       out  1   one-cycle pulse on timeout
//  misalign_trap out  1   one-cycle pulse on misaligned access (tied 0 without the macro)
// BEHAVIOUR
//  - Reset: FSM=IDLE; dmem_req, dmem_we, bus_err, misalign_trap = 0.
//    Reset values for dmem_addr, dmem_be, dmem_wdata, load_data: 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: on (mem_read|mem_write), stall=1 combinationally.
//    Register dmem_addr/be/wdata/we, set dmem_req=1 and clear the wait counter; next state BUSY.
//    With neither op, stall=0.
//  - BUSY: stall=1; dmem_req and all dmem_* outputs held stable.
//    On dmem_ack: capture load_data (reads only), drop dmem_req, go to DONE.
//    Without ack, counter increments; when it reaches MAX_WAIT: drop dmem_req, pulse bus_err,
//    leave load_data unchanged, go to DONE.
//  - DONE: stall=0 for exactly one cycle, so the instruction advances; next state IDLE.
//    A back-to-back memory op therefore starts in the following cycle.
//  - Minimum latency, ack in first BUSY cycle: 2 stall cycles per access.
//  - dmem_ack outside BUSY is ignored. Counter saturates and never wraps.
//  - Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//  - Write data: SB {4{sd[7:0]}}; SH {2{sd[15:0]}}; SW sd.
//  - Loads: dmem_be=4'b1111, dmem_we=0.
//  - Reset mid-access: dmem_req drops immediately (async); the pending ack is discarded.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request.
//    IDLE -> DONE directly with misalign_trap pulsed in DONE; load_data unchanged.
//  MISALIGN_TRAP_EN undefined:
//    Low address bits are ignored for alignment: H uses addr[1] only, W uses offset 0.
//    misalign_trap is tied 0.
// STRUCTURE
//  cpu_pkg: funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU; enum mau_state_t {IDLE,BUSY,DONE}.
//  Sub-module store_align (combinational):
//    (funct3, addr[1:0], store_data) -> (be, wdata, misaligned).
//  FSM, wait counter and load-shift register live in mem_access_unit.
// TESTING
//  1. SB addr=0x1003 sd=0xAABBCCDD, ack in 1st BUSY
//     -> be=4'b1000, wdata=0xDDDDDDDD, dmem_addr=0x1000, we=1, stall high 2 cycles.
//  2. LB addr=0x2002, rdata=0x11223344 with 3-cycle ack delay
//     -> load_data=0x00001122, stall high 4 cycles.
//  3. SH addr=0x3002 sd=0x0000BEEF -> be=4'b1100, wdata=0xBEEFBEEF.
//  4. Load with ack never asserted, MAX_WAIT=4
//     -> bus_err pulses once, dmem_req low, stall released in DONE.
//  5. Reset asserted during BUSY -> dmem_req=0 same cycle; later ack ignored; FSM in IDLE.
//  6. MISALIGN_TRAP_EN, LW addr=0x4001 -> no dmem_req, misalign_trap 1-cycle pulse.
//     Without the macro -> dmem_addr=0x4000, be=4'b1111.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared load/store definitions for the MEM stage: funct3
//               encodings, the access FSM state type and the load lane-offset
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  // Byte lane holding the addressed datum; low bits below the access size
  // are ignored so that loads stay naturally aligned.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: lane_offset = a;
      F3_H, F3_HU: lane_offset = {a[1], 1'b0};
      default:     lane_offset = 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Combinational byte-enable / write-data lane replication and
//               misalignment detection for one data-memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module store_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode access size into enables and replicated data; unknown sizes act as word.
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store engine. Issues a req/ack access to the
//               data memory, stalls the pipeline while it is outstanding,
//               aborts with bus_err after MAX_WAIT unacknowledged cycles and
//               returns right-justified load data.
//               Build option: define MISALIGN_TRAP_EN to trap misaligned
//               halfword/word accesses instead of silently aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign_trap
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);

  mau_state_t       state;
  mau_state_t       state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       load_shift;
  logic [3:0]       sa_be;
  logic [31:0]      sa_wdata;
  logic             sa_misaligned;
  logic             access_req;
  logic             trap_now;
  logic             start_access;
  logic             timeout;

  store_align u_store_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .be         (sa_be),
    .wdata      (sa_wdata),
    .misaligned (sa_misaligned)
  );

  assign access_req = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  assign trap_now = access_req & sa_misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = sa_misaligned;
  assign trap_now          = 1'b0;
`endif

  assign start_access = access_req & ~trap_now;
  // The MAX_WAIT-th BUSY cycle without an ack is the last one allowed.
  assign timeout      = (wait_cnt >= WAIT_LAST) & ~dmem_ack;

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: one access per IDLE->BUSY->DONE pass, traps skip BUSY.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (trap_now)          state_nx = DONE;
        else if (start_access) state_nx = BUSY;
      end
      BUSY: begin
        if (dmem_ack || timeout) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pipeline freeze: from the moment an op shows up until the access finishes.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access_req;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Memory interface registers, wait counter, load capture and event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_be       <= 4'h0;
      dmem_wdata    <= 32'h0;
      load_data     <= 32'h0;
      load_shift    <= 2'b00;
      wait_cnt      <= '0;
      bus_err       <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      bus_err       <= 1'b0;
      misalign_trap <= 1'b0;
      case (state)
        IDLE: begin
          if (start_access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= mem_write ? sa_be : 4'b1111;
            dmem_wdata <= sa_wdata;
            load_shift <= lane_offset(funct3, addr[1:0]);
            wait_cnt   <= '0;
          end else if (trap_now) begin
            misalign_trap <= 1'b1;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) load_data <= dmem_rdata >> {load_shift, 3'b000};
          end else begin
            if (wait_cnt < WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;
            if (timeout) begin
              dmem_req <= 1'b0;
              bus_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
